// File: rtl/pattern_pkg.sv
// Shared types and fixed-point helpers for the pattern generator.
package pattern_pkg;

  localparam int P_BITS     = 16;
  localparam int P_FRAC_DEF = 8;

  typedef logic [P_BITS-1:0] word_t;

  typedef enum logic {
    TGT_PARITY   = 1'b0,
    TGT_MAJORITY = 1'b1
  } tgt_mode_e;

  // Fixed-point 1.0 for a given number of fractional bits.
  function automatic int unsigned fx_one(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

endpackage

// File: rtl/pattern_target.sv
// Combinational pattern decode: index bits -> fixed-point x vector, plus target y.
module pattern_target
  import pattern_pkg::*;
#(
  parameter int NX   = 4,
  parameter int BITS = 16,
  parameter int FRAC = P_FRAC_DEF
) (
  input  logic [NX-1:0]           idx,
  input  tgt_mode_e               mode,
  output logic [NX-1:0][BITS-1:0] x,
  output logic [BITS-1:0]         y
);

  localparam logic [BITS-1:0] ONE = BITS'(fx_one(FRAC));

  logic hi;

  for (genvar k = 0; k < NX; k++) begin : g_lane
    assign x[k] = idx[k] ? ONE : '0;
  end

  always_comb begin
    hi = ^idx;
    if (mode == TGT_MAJORITY) hi = ($countones(idx) > (NX / 2));
    y = hi ? ONE : '0;
  end

endmodule

// File: rtl/pattern_gen.sv
// Training/validation pattern source with TRAIN/VALID/EPOCH counters and learning rate.
// LR_DECAY_EN: halve lr on every epoch, floored at one LSB.
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int              NX      = 4,
  parameter int              NH      = 6,
  parameter int              BITS    = 16,
  parameter int              FRAC    = P_FRAC_DEF,
  parameter logic [BITS-1:0] LR_INIT = 16'h0020
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    TR,
  input  logic                    VL,
  input  logic                    SW,
  input  logic [NX:0][BITS-1:0]   W1,
  input  logic [NH:0][BITS-1:0]   W2,
  output logic [BITS-1:0]         lr,
  output logic [NX-1:0][BITS-1:0] x,
  output logic [BITS-1:0]         y,
  output logic [BITS-1:0]         TRAIN,
  output logic [BITS-1:0]         VALID,
  output logic [BITS-1:0]         EPOCH
);

  logic                    tr_q, vl_q;
  logic                    tr_ev, vl_ev, ld, epoch_inc;
  logic [NX-1:0]           tidx_q, tidx_d, vidx_q, vidx_d, ld_idx;
  logic [NX-1:0][BITS-1:0] x_q, x_d, pat_x;
  logic [BITS-1:0]         y_q, y_d, pat_y;
  logic [BITS-1:0]         train_q, train_d, valid_q, valid_d, epoch_q, epoch_d;
  logic [BITS-1:0]         lr_q, lr_d;
  logic                    unused_w;

  // Weight ports are reserved for a later revision.
  assign unused_w = ^{W1, W2};

  // Training wins a tie; the simultaneous validation event is simply lost.
  assign tr_ev  = TR & ~tr_q;
  assign vl_ev  = VL & ~vl_q & ~tr_ev;
  assign ld     = tr_ev | vl_ev;
  assign ld_idx = tr_ev ? tidx_q : vidx_q;

  pattern_target #(.NX(NX), .BITS(BITS), .FRAC(FRAC)) u_target (
    .idx  (ld_idx),
    .mode (tgt_mode_e'(SW)),
    .x    (pat_x),
    .y    (pat_y)
  );

  always_comb begin
    tidx_d    = tidx_q;
    vidx_d    = vidx_q;
    train_d   = train_q;
    valid_d   = valid_q;
    epoch_d   = epoch_q;
    lr_d      = lr_q;
    x_d       = x_q;
    y_d       = y_q;
    epoch_inc = 1'b0;
    if (ld) begin
      x_d = pat_x;
      y_d = pat_y;
    end
    if (tr_ev) begin
      tidx_d    = tidx_q + NX'(1);
      train_d   = train_q + BITS'(1);
      epoch_inc = (tidx_q == '1);
    end
    if (vl_ev) begin
      vidx_d  = vidx_q + NX'(1);
      valid_d = valid_q + BITS'(1);
    end
    if (epoch_inc) begin
      epoch_d = epoch_q + BITS'(1);
`ifdef LR_DECAY_EN
      lr_d = ((lr_q >> 1) == '0) ? BITS'(1) : (lr_q >> 1);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tr_q    <= 1'b0;
      vl_q    <= 1'b0;
      tidx_q  <= '0;
      vidx_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      train_q <= '0;
      valid_q <= '0;
      epoch_q <= '0;
      lr_q    <= LR_INIT;
    end else begin
      tr_q    <= TR;
      vl_q    <= VL;
      tidx_q  <= tidx_d;
      vidx_q  <= vidx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      train_q <= train_d;
      valid_q <= valid_d;
      epoch_q <= epoch_d;
      lr_q    <= lr_d;
    end
  end

  assign lr    = lr_q;
  assign x     = x_q;
  assign y     = y_q;
  assign TRAIN = train_q;
  assign VALID = valid_q;
  assign EPOCH = epoch_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Randomized self-checking bench for pattern_gen against a behavioural model.
module tb_pattern_gen;

  localparam int NX = 4;
  localparam int NH = 6;
  localparam int B  = 16;
  localparam logic [B-1:0] ONE = 16'h0100;
  localparam logic [B-1:0] LRI = 16'h0020;

  logic clk = 1'b0, rst = 1'b1, TR = 1'b0, VL = 1'b0, SW = 1'b0;
  logic [NX:0][B-1:0]   W1;
  logic [NH:0][B-1:0]   W2;
  logic [B-1:0]         lr, y, TRAIN, VALID, EPOCH;
  logic [NX-1:0][B-1:0] x;

  int checks = 0, failures = 0;

  // model state
  int m_tidx, m_vidx, m_train, m_valid, m_epoch, m_lr;
  logic [NX-1:0][B-1:0] m_x;
  logic [B-1:0]         m_y;

  pattern_gen u_dut (
    .clk(clk), .rst(rst), .TR(TR), .VL(VL), .SW(SW), .W1(W1), .W2(W2),
    .lr(lr), .x(x), .y(y), .TRAIN(TRAIN), .VALID(VALID), .EPOCH(EPOCH)
  );

  always #5 clk = ~clk;

  function automatic logic [143:0] act_vec();
    return {x, y, TRAIN, VALID, EPOCH, lr};
  endfunction

  function automatic logic [143:0] exp_vec();
    return {m_x, m_y, B'(m_train), B'(m_valid), B'(m_epoch), B'(m_lr)};
  endfunction

  function automatic void m_reset();
    m_tidx = 0; m_vidx = 0; m_train = 0; m_valid = 0; m_epoch = 0;
    m_lr = LRI; m_x = '0; m_y = '0;
  endfunction

  function automatic void m_load(input int idx, input logic sw);
    int cnt = 0;
    for (int k = 0; k < NX; k++) begin
      m_x[k] = ((idx >> k) & 1) != 0 ? ONE : 16'h0;
      cnt += (idx >> k) & 1;
    end
    m_y = (sw ? (cnt > NX / 2) : (cnt % 2 == 1)) ? ONE : 16'h0;
  endfunction

  // Drives one request and advances the model; outputs are settled on return.
  task automatic pulse(input logic tr, input logic vl, input logic sw, input int hold);
    @(negedge clk);
    TR = tr; VL = vl; SW = sw;
    repeat (hold) @(negedge clk);
    TR = 1'b0; VL = 1'b0;
    if (tr) begin
      m_load(m_tidx, sw);
      m_train = (m_train + 1) % 65536;
      if (m_tidx == 15) begin
        m_epoch = (m_epoch + 1) % 65536;
`ifdef LR_DECAY_EN
        m_lr = (m_lr / 2 < 1) ? 1 : m_lr / 2;
`endif
      end
      m_tidx = (m_tidx + 1) % 16;
    end else if (vl) begin
      m_load(m_vidx, sw);
      m_valid = (m_valid + 1) % 65536;
      m_vidx = (m_vidx + 1) % 16;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (act_vec() !== exp_vec() || lr !== LRI) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_first_pulses();
    pulse(1, 0, 0, 1);
    checks++;
    if (x !== '0 || y !== 16'h0 || TRAIN !== 16'd1 || EPOCH !== 16'd0 || lr !== LRI) begin
      failures++;
      $display("FAIL first_tr got=%h exp x=0 y=0 TRAIN=1", act_vec());
    end
    pulse(1, 0, 0, 1);
    checks++;
    if (x[0] !== ONE || x[3:1] !== '0 || y !== ONE || TRAIN !== 16'd2) begin
      failures++;
      $display("FAIL second_tr got=%h exp x0=0100 y=0100 TRAIN=2", act_vec());
    end
  endtask

  task automatic test_held_level();
    pulse(1, 0, 0, 3);
    repeat (2) @(negedge clk);
    checks++;
    if (act_vec() !== exp_vec() || TRAIN !== 16'd3) begin
      failures++;
      $display("FAIL held_tr got=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_epochs();
    do_reset();
    for (int e = 0; e < 7; e++) begin
      for (int p = 0; p < 16; p++) begin
        pulse(1, 0, 1'($urandom_range(0, 1)), 1);
        checks++;
        if (act_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL epoch_seq e=%0d p=%0d got=%h exp=%h", e, p, act_vec(), exp_vec());
        end
      end
      checks++;
      if (EPOCH !== B'(e + 1)) begin
        failures++;
        $display("FAIL epoch_count got=%0d exp=%0d", EPOCH, e + 1);
      end
    end
    pulse(1, 0, 0, 1);
    checks++;
    if (x !== '0 || y !== 16'h0) begin
      failures++;
      $display("FAIL epoch_wrap_pattern0 got x=%h y=%h exp 0", x, y);
    end
`ifdef LR_DECAY_EN
    checks++;
    if (lr !== 16'h0001) begin
      failures++;
      $display("FAIL lr_floor got=%h exp=0001", lr);
    end
`else
    checks++;
    if (lr !== LRI) begin
      failures++;
      $display("FAIL lr_const got=%h exp=%h", lr, LRI);
    end
`endif
  endtask

  task automatic test_valid();
    do_reset();
    repeat (4) pulse(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      pulse(0, 1, 0, 1);
      checks++;
      if (act_vec() !== exp_vec() || VALID !== B'(i + 1) || TRAIN !== 16'd4 || EPOCH !== 16'd0) begin
        failures++;
        $display("FAIL valid_seq i=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_majority();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pulse(0, 1, 1, 1);
      if (i == 6) begin
        checks++;
        if (y !== 16'h0) begin
          failures++;
          $display("FAIL maj_p6 got=%h exp=0000", y);
        end
      end
    end
    checks++;
    if (y !== ONE || act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL maj_p7 got=%h exp=0100", y);
    end
    SW = 1'b0;
    repeat (3) @(negedge clk);
    SW = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (y !== ONE) begin
      failures++;
      $display("FAIL maj_hold got=%h exp=0100", y);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (2) pulse(0, 1, 0, 1);
    repeat (5) pulse(1, 0, 0, 1);
    pulse(1, 1, 0, 1);
    checks++;
    if (act_vec() !== exp_vec() || TRAIN !== 16'd6 || VALID !== 16'd2) begin
      failures++;
      $display("FAIL simultaneous got=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(1, 3)));
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random i=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_mid_reset();
    repeat (5) pulse(1, 0, 0, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    m_reset();
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL mid_reset got=%h exp=%h", act_vec(), exp_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    pulse(1, 0, 0, 1);
    checks++;
    if (act_vec() !== exp_vec() || x !== '0 || TRAIN !== 16'd1) begin
      failures++;
      $display("FAIL after_reset got=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  initial begin
    for (int k = 0; k <= NX; k++) W1[k] = B'($urandom);
    for (int k = 0; k <= NH; k++) W2[k] = B'($urandom);
    m_reset();
    test_reset();
    test_first_pulses();
    test_held_level();
    test_epochs();
    test_valid();
    test_majority();
    test_simultaneous();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
